btn_conditioner: RTL and testbench

BTN_CONDITIONER -- requirements
Module: btn_conditioner

---
 rtl/btn_conditioner.sv | 143 ++++++++++++++
 tb/tb_btn_conditioner.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_conditioner.sv
// Button conditioner: 2-flop synchronizer, debounce FSM and registered press/release pulses.
// Define BTN_AUTOREPEAT_EN to add auto-repeat PRESS pulses while the button stays held.
module btn_conditioner #(
   parameter int FPGAFREQ        = 50_000_000,
   parameter int DEBOUNCE_MS     = 20,
   parameter int REPEAT_DELAY_MS = 500,
   parameter int REPEAT_RATE_MS  = 100
) (
   input  logic CLK,
   input  logic RST,
   input  logic BTN_IN,
   output logic BTN_LEVEL,
   output logic PRESS,
   output logic RELEASE
);

   localparam int TICKS_PER_MS = FPGAFREQ / 1000;
   localparam int N_RAW        = TICKS_PER_MS * DEBOUNCE_MS;
   localparam int N            = (N_RAW < 1) ? 1 : N_RAW;
   localparam int R0_RAW       = TICKS_PER_MS * REPEAT_DELAY_MS;
   localparam int R0           = (R0_RAW < 1) ? 1 : R0_RAW;
   localparam int R1_RAW       = TICKS_PER_MS * REPEAT_RATE_MS;
   localparam int R1           = (R1_RAW < 1) ? 1 : R1_RAW;

`ifdef BTN_AUTOREPEAT_EN
   localparam bit AUTOREPEAT = 1'b1;
`else
   localparam bit AUTOREPEAT = 1'b0;
`endif

   localparam int MAX_R     = (R0 > R1) ? R0 : R1;
   localparam int MAX_COUNT = (AUTOREPEAT && (MAX_R > N)) ? MAX_R : N;
   localparam int CW_RAW    = $clog2(MAX_COUNT);
   localparam int CW        = (CW_RAW < 1) ? 1 : CW_RAW;

   localparam logic [CW-1:0] N_LAST = CW'(N - 1);

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      HELD         = 2'd2,
      RELEASE_WAIT = 2'd3
   } state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic          sync_meta;
   logic          s;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         sync_meta <= 1'b0;
         s         <= 1'b0;
      end else begin
         sync_meta <= BTN_IN;
         s         <= sync_meta;
      end
   end

`ifdef BTN_AUTOREPEAT_EN
   localparam logic [CW-1:0] R0_LAST = CW'(R0 - 1);
   localparam logic [CW-1:0] R1_LAST = CW'(R1 - 1);

   logic [CW-1:0] rpt_timer;
   logic          repeating;
   logic [CW-1:0] rpt_target;

   assign rpt_target = repeating ? R1_LAST : R0_LAST;
`endif

   // Counters only ever step up to their terminal value, so they saturate rather than wrap.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state     <= IDLE;
         cnt       <= '0;
         BTN_LEVEL <= 1'b0;
         PRESS     <= 1'b0;
         RELEASE   <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
         rpt_timer <= '0;
         repeating <= 1'b0;
`endif
      end else begin
         PRESS   <= 1'b0;
         RELEASE <= 1'b0;
         case (state)
            IDLE: begin
               if (s) begin
                  state <= PRESS_WAIT;
                  cnt   <= '0;
               end
            end
            PRESS_WAIT: begin
               if (!s) begin
                  state <= IDLE;
               end else if (cnt == N_LAST) begin
                  state     <= HELD;
                  PRESS     <= 1'b1;
                  BTN_LEVEL <= 1'b1;
`ifdef BTN_AUTOREPEAT_EN
                  rpt_timer <= '0;
                  repeating <= 1'b0;
`endif
               end else if (cnt < N_LAST) begin
                  cnt <= cnt + CW'(1);
               end
            end
            HELD: begin
               if (!s) begin
                  state <= RELEASE_WAIT;
                  cnt   <= '0;
               end
`ifdef BTN_AUTOREPEAT_EN
               else if (rpt_timer == rpt_target) begin
                  PRESS     <= 1'b1;
                  rpt_timer <= '0;
                  repeating <= 1'b1;
               end else if (rpt_timer < rpt_target) begin
                  rpt_timer <= rpt_timer + CW'(1);
               end
`endif
            end
            RELEASE_WAIT: begin
               // A bounce back to high resumes HELD with the repeat timer left where it froze.
               if (s) begin
                  state <= HELD;
               end else if (cnt == N_LAST) begin
                  state     <= IDLE;
                  RELEASE   <= 1'b1;
                  BTN_LEVEL <= 1'b0;
               end else if (cnt < N_LAST) begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed self-checking bench for btn_conditioner with N=5 cycles debounce
// (FPGAFREQ=1000, DEBOUNCE_MS=5, REPEAT_DELAY_MS=20, REPEAT_RATE_MS=10).
module tb_btn_conditioner;

   logic CLK;
   logic RST;
   logic BTN_IN;
   logic BTN_LEVEL;
   logic PRESS;
   logic RELEASE;

   int assertions = 0;
   int failures   = 0;

   btn_conditioner #(
      .FPGAFREQ(1000),
      .DEBOUNCE_MS(5),
      .REPEAT_DELAY_MS(20),
      .REPEAT_RATE_MS(10)
   ) dut (
      .CLK(CLK),
      .RST(RST),
      .BTN_IN(BTN_IN),
      .BTN_LEVEL(BTN_LEVEL),
      .PRESS(PRESS),
      .RELEASE(RELEASE)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Inputs change and outputs are sampled on the falling edge, so "after edge i" means
   // the i-th negedge following the input change.
   task automatic settle_low(input int cycles);
      BTN_IN = 1'b0;
      for (int i = 0; i < cycles; i++) @(negedge CLK);
   endtask

   task automatic test_reset;
      RST    = 1'b1;
      BTN_IN = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         @(negedge CLK);
         assertions++;
         if ({BTN_LEVEL, PRESS, RELEASE} !== 3'b000) begin
            failures++;
            $display("[TB] FAIL reset_outputs cycle %0d: got %b expected 000", i, {BTN_LEVEL, PRESS, RELEASE});
         end
      end
      RST = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         @(negedge CLK);
         assertions++;
         if ({BTN_LEVEL, PRESS, RELEASE} !== 3'b000) begin
            failures++;
            $display("[TB] FAIL post_reset_idle cycle %0d: got %b expected 000", i, {BTN_LEVEL, PRESS, RELEASE});
         end
      end
   endtask

   task automatic test_clean_press;
      BTN_IN = 1'b1;
      for (int i = 1; i <= 30; i++) begin
         @(negedge CLK);
         assertions++;
         if (PRESS !== (i == 8)) begin
            failures++;
            $display("[TB] FAIL clean_press_pulse edge %0d: got %b expected %b", i, PRESS, (i == 8));
         end
         assertions++;
         if (BTN_LEVEL !== (i >= 8)) begin
            failures++;
            $display("[TB] FAIL clean_press_level edge %0d: got %b expected %b", i, BTN_LEVEL, (i >= 8));
         end
         assertions++;
         if (RELEASE !== 1'b0) begin
            failures++;
            $display("[TB] FAIL clean_press_norelease edge %0d: got %b expected 0", i, RELEASE);
         end
      end
      BTN_IN = 1'b0;
      for (int i = 1; i <= 12; i++) begin
         @(negedge CLK);
         assertions++;
         if (RELEASE !== (i == 8)) begin
            failures++;
            $display("[TB] FAIL clean_release_pulse edge %0d: got %b expected %b", i, RELEASE, (i == 8));
         end
         assertions++;
         if (BTN_LEVEL !== (i < 8)) begin
            failures++;
            $display("[TB] FAIL clean_release_level edge %0d: got %b expected %b", i, BTN_LEVEL, (i < 8));
         end
         assertions++;
         if (PRESS !== 1'b0) begin
            failures++;
            $display("[TB] FAIL clean_release_nopress edge %0d: got %b expected 0", i, PRESS);
         end
      end
   endtask

   task automatic test_bounce;
      for (int i = 1; i <= 24; i++) begin
         BTN_IN = (i <= 2) || (i >= 5 && i <= 6);
         @(negedge CLK);
         assertions++;
         if ({BTN_LEVEL, PRESS, RELEASE} !== 3'b000) begin
            failures++;
            $display("[TB] FAIL bounce_rejected edge %0d: got %b expected 000", i, {BTN_LEVEL, PRESS, RELEASE});
         end
      end
      // A fresh clean press must qualify with the full latency, which only holds from IDLE.
      BTN_IN = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         @(negedge CLK);
         assertions++;
         if (PRESS !== (i == 8)) begin
            failures++;
            $display("[TB] FAIL bounce_then_press edge %0d: got %b expected %b", i, PRESS, (i == 8));
         end
      end
      settle_low(15);
   endtask

   task automatic test_release_glitch;
      BTN_IN = 1'b1;
      for (int i = 0; i < 12; i++) @(negedge CLK);
      assertions++;
      if (BTN_LEVEL !== 1'b1) begin
         failures++;
         $display("[TB] FAIL glitch_setup_level: got %b expected 1", BTN_LEVEL);
      end
      for (int i = 1; i <= 13; i++) begin
         BTN_IN = (i > 3);
         @(negedge CLK);
         assertions++;
         if ({BTN_LEVEL, PRESS, RELEASE} !== 3'b100) begin
            failures++;
            $display("[TB] FAIL glitch_ignored edge %0d: got %b expected 100", i, {BTN_LEVEL, PRESS, RELEASE});
         end
      end
      BTN_IN = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         @(negedge CLK);
         assertions++;
         if (RELEASE !== (i == 8)) begin
            failures++;
            $display("[TB] FAIL glitch_release_pulse edge %0d: got %b expected %b", i, RELEASE, (i == 8));
         end
         assertions++;
         if (BTN_LEVEL !== (i < 8)) begin
            failures++;
            $display("[TB] FAIL glitch_release_level edge %0d: got %b expected %b", i, BTN_LEVEL, (i < 8));
         end
      end
      settle_low(5);
   endtask

   task automatic test_reset_mid;
      BTN_IN = 1'b1;
      for (int i = 0; i < 5; i++) @(negedge CLK);
      RST = 1'b1;
      #1;
      assertions++;
      if ({BTN_LEVEL, PRESS, RELEASE} !== 3'b000) begin
         failures++;
         $display("[TB] FAIL reset_mid_debounce_async: got %b expected 000", {BTN_LEVEL, PRESS, RELEASE});
      end
      for (int i = 1; i <= 3; i++) begin
         @(negedge CLK);
         assertions++;
         if ({BTN_LEVEL, PRESS, RELEASE} !== 3'b000) begin
            failures++;
            $display("[TB] FAIL reset_mid_debounce_hold cycle %0d: got %b expected 000", i, {BTN_LEVEL, PRESS, RELEASE});
         end
      end
      RST = 1'b0;
      for (int i = 1; i <= 12; i++) begin
         @(negedge CLK);
         assertions++;
         if (PRESS !== (i == 8)) begin
            failures++;
            $display("[TB] FAIL reset_mid_requalify edge %0d: got %b expected %b", i, PRESS, (i == 8));
         end
         assertions++;
         if (BTN_LEVEL !== (i >= 8)) begin
            failures++;
            $display("[TB] FAIL reset_mid_level edge %0d: got %b expected %b", i, BTN_LEVEL, (i >= 8));
         end
      end
      // Reset while HELD drops the level and forces a second qualification.
      RST = 1'b1;
      #1;
      assertions++;
      if ({BTN_LEVEL, PRESS, RELEASE} !== 3'b000) begin
         failures++;
         $display("[TB] FAIL reset_mid_hold_async: got %b expected 000", {BTN_LEVEL, PRESS, RELEASE});
      end
      @(negedge CLK);
      RST = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         @(negedge CLK);
         assertions++;
         if ({PRESS, RELEASE} !== {(i == 8), 1'b0}) begin
            failures++;
            $display("[TB] FAIL reset_hold_requalify edge %0d: got %b expected %b", i, {PRESS, RELEASE}, {(i == 8), 1'b0});
         end
      end
      settle_low(15);
   endtask

   task automatic test_autorepeat;
      int  press_count;
      logic exp_press;
      int  exp_count;
      press_count = 0;
`ifdef BTN_AUTOREPEAT_EN
      exp_count = 4;
`else
      exp_count = 1;
`endif
      for (int i = 1; i <= 67; i++) begin
         BTN_IN = (i <= 52);
`ifdef BTN_AUTOREPEAT_EN
         exp_press = (i == 8) || (i == 28) || (i == 38) || (i == 48);
`else
         exp_press = (i == 8);
`endif
         @(negedge CLK);
         if (PRESS === 1'b1) press_count++;
         assertions++;
         if (PRESS !== exp_press) begin
            failures++;
            $display("[TB] FAIL hold_press_pulse edge %0d: got %b expected %b", i, PRESS, exp_press);
         end
         assertions++;
         if (RELEASE !== (i == 60)) begin
            failures++;
            $display("[TB] FAIL hold_release_pulse edge %0d: got %b expected %b", i, RELEASE, (i == 60));
         end
      end
      assertions++;
      if (press_count !== exp_count) begin
         failures++;
         $display("[TB] FAIL hold_press_count: got %0d expected %0d", press_count, exp_count);
      end
   endtask

   initial begin
      RST    = 1'b1;
      BTN_IN = 1'b0;
      test_reset();
      test_clean_press();
      test_bounce();
      test_release_glitch();
      test_reset_mid();
      test_autorepeat();
      $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
      $finish;
   end

endmodule
